dbg_cmd_frontend: RTL

- Upstream master for the debug command bus.
- Receives a byte stream from a serial host link (UART RX side) and assembles command frames.
- Drives cmd/addr/data onto the debug bus, waits for the DUT's completion strobe, then returns the DUT's read data as a byte stream to the link TX side.
- Sits between the UART byte FIFOs and the debug port of the core under debug.

---
 rtl/dbg_cmd_frontend.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/dbg_cmd_frontend.sv
// Debug command bus front end.
// Assembles host frames (cmd, addr MSB-first, data MSB-first) from the RX
// byte stream, runs one debug bus cycle per non-NOP frame, and streams the
// DUT response (or an abort pattern after a timeout) back MSB-first.
module dbg_cmd_frontend #(
    parameter int unsigned BITSIZE = 32,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               rstn_i,
    input  logic [7:0]         rx_data_i,
    input  logic               rx_valid_i,
    output logic               rx_ready_o,
    output logic [7:0]         tx_data_o,
    output logic               tx_valid_o,
    input  logic               tx_ready_i,
    output logic [7:0]         cmd_o,
    output logic [BITSIZE-1:0] addr_o,
    output logic [BITSIZE-1:0] data_o,
    input  logic [BITSIZE-1:0] data_i,
    input  logic               dut_done_i,
    output logic               busy_o,
    output logic               timeout_o
);

    localparam int unsigned NB = BITSIZE / 8;
    localparam int unsigned CW = $clog2(NB) + 1;
    localparam int unsigned TW = $clog2(TIMEOUT);

    localparam logic [CW-1:0] LAST_BYTE = CW'(NB - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

    // 0xDEADBEEF repeated across the word; narrower words keep the low bits.
    function automatic logic [BITSIZE-1:0] abort_pattern();
        logic [31:0]        word;
        logic [BITSIZE-1:0] pat;
        word = 32'hDEADBEEF;
        pat  = '0;
        for (int unsigned i = 0; i < BITSIZE; i++) begin
            pat[i] = word[i[4:0]];
        end
        return pat;
    endfunction

    localparam logic [BITSIZE-1:0] ABORT_WORD = abort_pattern();

    // Shift one byte into the low end of a word (works for BITSIZE = 8 too).
    function automatic logic [BITSIZE-1:0] shift_in(
        input logic [BITSIZE-1:0] word,
        input logic [7:0]         b
    );
        logic [BITSIZE-1:0] res;
        res      = word << 8;
        res[7:0] = b;
        return res;
    endfunction

    typedef enum logic [2:0] {
        RX_CMD,
        RX_ADDR,
        RX_DATA,
        EXEC,
        TX
    } state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q,   cnt_d;
    logic [TW-1:0]      tmo_q,   tmo_d;
    logic [7:0]         cmd_q,   cmd_d;
    logic [BITSIZE-1:0] addr_q,  addr_d;
    logic [BITSIZE-1:0] data_q,  data_d;
    logic [BITSIZE-1:0] resp_q,  resp_d;

    logic rx_fire;
    logic tx_fire;

    // Output decode: handshake readiness and bus command follow the state.
    always_comb begin
        rx_ready_o = (state_q == RX_CMD) || (state_q == RX_ADDR) || (state_q == RX_DATA);
        tx_valid_o = (state_q == TX);
        tx_data_o  = resp_q[BITSIZE-1 -: 8];
        cmd_o      = (state_q == EXEC) ? cmd_q : 8'h00;
        addr_o     = addr_q;
        data_o     = data_q;
        busy_o     = (state_q != RX_CMD);
        rx_fire    = rx_valid_i && rx_ready_o;
        tx_fire    = tx_valid_o && tx_ready_i;
    end

    // Next-state logic: frame assembly, bus cycle with timeout, response shift-out.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        cmd_d     = cmd_q;
        addr_d    = addr_q;
        data_d    = data_q;
        resp_d    = resp_q;
        timeout_o = 1'b0;

        unique case (state_q)
            RX_CMD: begin
                if (rx_fire) begin
                    cmd_d   = rx_data_i;
                    cnt_d   = '0;
                    state_d = RX_ADDR;
                end
            end

            RX_ADDR: begin
                if (rx_fire) begin
                    addr_d = shift_in(addr_q, rx_data_i);
                    if (cnt_q == LAST_BYTE) begin
                        cnt_d   = '0;
                        state_d = RX_DATA;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            RX_DATA: begin
                if (rx_fire) begin
                    data_d = shift_in(data_q, rx_data_i);
                    if (cnt_q == LAST_BYTE) begin
                        cnt_d = '0;
                        tmo_d = '0;
                        // A zero command is a NOP frame: no bus cycle, no response.
                        state_d = (cmd_q == 8'h00) ? RX_CMD : EXEC;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            EXEC: begin
                // Done takes priority over a timeout landing in the same cycle.
                if (dut_done_i) begin
                    resp_d  = data_i;
                    cnt_d   = '0;
                    state_d = TX;
                end else if (tmo_q == TMO_LAST) begin
                    timeout_o = 1'b1;
                    resp_d    = ABORT_WORD;
                    cnt_d     = '0;
                    state_d   = TX;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end

            TX: begin
                if (tx_fire) begin
                    resp_d = resp_q << 8;
                    if (cnt_q == LAST_BYTE) begin
                        cnt_d   = '0;
                        state_d = RX_CMD;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            default: begin
                state_d = RX_CMD;
                cnt_d   = '0;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn_i) begin
            state_q <= RX_CMD;
            cnt_q   <= '0;
            tmo_q   <= '0;
            cmd_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            resp_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            resp_q  <= resp_d;
        end
    end

endmodule
